dense_par: RTL and testbench
============================

DENSE_PAR -- requirements
Module: dense_par

Interface
REQ-001 Parameter IN_COUNT, default 16: number of input activations.
REQ-002 Parameter OUT_COUNT, default 10: number of output neurons.
REQ-003 Parameter DATA_SIZE, default 16: signed fixed-point word width.
REQ-004 Parameter FRAC_BITS, default 8: fractional bits of every word.
REQ-005 Parameter LANES, default 2: neurons computed in parallel; OUT_COUNT % LANES == 0, elaboration error otherwise.
REQ-006 Parameter RELU_EN, default 1: 1 enables ReLU on outputs.
REQ-007 clk  in  1  the single clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  begin a frame; sampled only in IDLE.
REQ-010 in_valid / in_data / in_ready  in/in/out  1/DATA_SIZE/1  input activation stream; a word transfers when in_valid && in_ready.
REQ-011 weight_adr  out  clog2(IN_COUNT*OUT_COUNT/LANES)  weight-ROM row; weight_data  in  LANES*DATA_SIZE  row, lane L in bits [L*DATA_SIZE +: DATA_SIZE].
REQ-012 bias_adr  out  clog2(OUT_COUNT/LANES)  bias-ROM row; bias_data  in  LANES*DATA_SIZE  same lane packing.
REQ-013 out_valid / out_data / out_ready / out_last  out/out/in/out  1/DATA_SIZE/1/1  result stream; out_last marks neuron OUT_COUNT-1.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 States IDLE, LOAD, MAC, BIAS, OUT; IDLE->LOAD on start; LOAD->MAC after IN_COUNT transfers; MAC->BIAS after IN_COUNT+1 cycles; BIAS->OUT after 1 cycle; OUT->MAC (next group) or ->IDLE after last group drained.
REQ-016 LOAD: in_ready=1; words stored in an internal buffer at index 0..IN_COUNT-1 in arrival order; in_ready=0 in all other states.
REQ-017 ROMs are synchronous, 1-cycle read latency; weight_adr = g*IN_COUNT + i for group g, input i; bias_adr = g held for the whole group.
REQ-018 MAC: accumulator per lane, width 2*DATA_SIZE+clog2(IN_COUNT)+1, cleared on MAC entry, acc += in[i]*w[g][i] (signed full product), exactly IN_COUNT products per lane.
REQ-019 BIAS: acc += sign-extended bias << FRAC_BITS; result = acc >>> FRAC_BITS (arithmetic, truncation), saturated to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1], then negative -> 0 if RELU_EN; stored in LANES output registers.
REQ-020 OUT: lane registers emitted in order lane 0..LANES-1, neuron index g*LANES+L; word advances only when out_valid && out_ready; out_data/out_valid stable while out_ready=0.
REQ-021 out_last=1 with out_valid only for neuron OUT_COUNT-1; group and lane counters wrap to 0 on return to IDLE.
REQ-022 start while busy is ignored; in_valid outside LOAD is ignored (no transfer).
REQ-023 Latency, no stalls: first out_valid exactly IN_COUNT+1+IN_COUNT+1+1 cycles after start accepted (LOAD+MAC+BIAS).
REQ-024 Input buffer retained across groups; one frame = one LOAD.

Reset
REQ-025 rst forces IDLE, clears all counters and accumulators; outputs in_ready, out_valid, out_last, busy = 0, out_data, weight_adr, bias_adr = 0.
REQ-026 rst mid-frame aborts immediately; no further output words; next start begins a clean frame.

Structure
REQ-027 Package dense_pkg holds the state enum, accumulator-width function and saturate/ReLU constants.
REQ-028 One sub-module dense_lane (per-lane MAC, bias add, shift, saturate, ReLU), instantiated LANES times via generate.

Verification
REQ-029 IN=4,OUT=2,LANES=2, inputs all 1.0 (0x0100), weights 1.0, bias 0 -> outputs 0x0400, 0x0400, out_last on second.
REQ-030 Input 0x7F00 x16, weights 0x7F00, bias 0 -> every output 0x7FFF (positive saturation); weights negated, RELU_EN=0 -> 0x8000, RELU_EN=1 -> 0x0000.
REQ-031 Bias -2.0 (0xFE00), products sum 1.5 -> RELU_EN=0 output 0xFF80, RELU_EN=1 output 0x0000.
REQ-032 out_ready held low 5 cycles at each word -> out_data constant during stall, all OUT_COUNT words delivered once in order.
REQ-033 rst asserted in MAC of group 1 -> busy=0, out_valid=0 next cycle; following start with known vectors yields correct results.
REQ-034 start pulsed during OUT and in_valid during MAC -> no effect; cycle count to first out_valid = 2*IN_COUNT+3.

Source files
------------

// File: rtl/dense_pkg.sv
// dense_pkg: shared state encoding, width helpers and saturation bounds for the dense layer
package dense_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        BIAS = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam int RELU_FLOOR = 0;

    function automatic int acc_width(input int d, input int n);
        return 2 * d + $clog2(n) + 1;
    endfunction

    function automatic int addr_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic longint sat_hi(input int d);
        return (longint'(1) <<< (d - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int d);
        return -(longint'(1) <<< (d - 1));
    endfunction

endpackage

// File: rtl/dense_par_lane.sv
// dense_lane: one neuron lane -- multiply-accumulate, bias add, rescale, saturate, optional ReLU
module dense_lane import dense_pkg::*; #(
    parameter int IN_COUNT  = 16,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int RELU_EN   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        mac_en,
    input  logic                        bias_en,
    input  logic signed [DATA_SIZE-1:0] a,
    input  logic signed [DATA_SIZE-1:0] w,
    input  logic signed [DATA_SIZE-1:0] b,
    output logic        [DATA_SIZE-1:0] result
);

    localparam int AW = acc_width(DATA_SIZE, IN_COUNT);
    localparam int PW = 2 * DATA_SIZE;
    localparam logic signed [AW-1:0] HI = AW'(sat_hi(DATA_SIZE));
    localparam logic signed [AW-1:0] LO = AW'(sat_lo(DATA_SIZE));

    logic signed [PW-1:0] full;
    logic signed [AW-1:0] acc, prod, bias_ext, sum, shifted, clamped;
    logic        [DATA_SIZE-1:0] res_n;

    // full-precision product, bias aligned to the accumulator's fixed point, then rescale and clamp
    always_comb begin
        full     = PW'(a) * PW'(w);
        prod     = AW'(full);
        bias_ext = AW'(b);
        sum      = acc + (bias_ext <<< FRAC_BITS);
        shifted  = sum >>> FRAC_BITS;
        clamped  = shifted > HI ? HI : shifted < LO ? LO : shifted;
        res_n    = (RELU_EN != 0 && clamped[AW-1]) ? DATA_SIZE'(RELU_FLOOR) : DATA_SIZE'(clamped);
    end

    // accumulator cleared at the start of each group; result latched once per group
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (mac_en)
                acc <= acc + prod;
            if (bias_en)
                result <= res_n;
        end
    end

endmodule

// File: rtl/dense_par.sv
// dense_par: fully connected layer computing LANES neurons at a time from a buffered input frame
module dense_par import dense_pkg::*; #(
    parameter int IN_COUNT  = 16,
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 2,
    parameter int RELU_EN   = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic                                                in_valid,
    input  logic [DATA_SIZE-1:0]                                in_data,
    output logic                                                in_ready,
    output logic [addr_width(IN_COUNT*OUT_COUNT/LANES)-1:0]     weight_adr,
    input  logic [LANES*DATA_SIZE-1:0]                          weight_data,
    output logic [addr_width(OUT_COUNT/LANES)-1:0]              bias_adr,
    input  logic [LANES*DATA_SIZE-1:0]                          bias_data,
    output logic                                                out_valid,
    output logic [DATA_SIZE-1:0]                                out_data,
    input  logic                                                out_ready,
    output logic                                                out_last,
    output logic                                                busy
);

    localparam int GROUPS = OUT_COUNT / LANES;
    localparam int WA_W   = addr_width(IN_COUNT * GROUPS);
    localparam int BA_W   = addr_width(GROUPS);
    localparam int KW     = addr_width(IN_COUNT + 1);
    localparam int IW     = addr_width(IN_COUNT);
    localparam int LW     = addr_width(LANES);
    localparam logic [KW-1:0]   K_LAST = KW'(IN_COUNT - 1);
    localparam logic [KW-1:0]   K_END  = KW'(IN_COUNT);
    localparam logic [BA_W-1:0] G_LAST = BA_W'(GROUPS - 1);
    localparam logic [LW-1:0]   L_LAST = LW'(LANES - 1);

    if (OUT_COUNT % LANES != 0) begin : g_bad_lanes
        $error("dense_par: OUT_COUNT must be a multiple of LANES");
    end

    state_t              state;
    logic [KW-1:0]       k;
    logic [BA_W-1:0]     grp;
    logic [LW-1:0]       lane;
    logic [IW-1:0]       ia;
    logic [DATA_SIZE-1:0] ibuf [IN_COUNT];
    logic [DATA_SIZE-1:0] a_q;
    logic [DATA_SIZE-1:0] res [LANES];
    logic                 in_fire, out_fire;

    assign in_ready   = state == LOAD;
    assign busy       = state != IDLE;
    assign out_valid  = state == OUT;
    assign out_last   = out_valid && grp == G_LAST && lane == L_LAST;
    assign out_data   = res[lane];
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign weight_adr = WA_W'(int'(grp) * IN_COUNT + int'(k));
    assign bias_adr   = grp;
    assign ia         = (k < K_END) ? IW'(k) : '0;

    // frame sequencing: k counts loaded words in LOAD and MAC steps in MAC; grp/lane walk the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            grp   <= '0;
            lane  <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= LOAD;
                LOAD: if (in_fire) begin
                    k     <= (k == K_LAST) ? '0 : k + 1'b1;
                    state <= (k == K_LAST) ? MAC : LOAD;
                end
                MAC: begin
                    k     <= (k == K_END) ? '0 : k + 1'b1;
                    state <= (k == K_END) ? BIAS : MAC;
                end
                BIAS: state <= OUT;
                OUT: if (out_fire) begin
                    lane <= (lane == L_LAST) ? '0 : lane + 1'b1;
                    if (lane == L_LAST) begin
                        grp   <= (grp == G_LAST) ? '0 : grp + 1'b1;
                        state <= (grp == G_LAST) ? IDLE : MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // capture the frame and delay the activation one cycle to line up with the weight ROM read
    always_ff @(posedge clk) begin
        if (in_fire) ibuf[IW'(k)] <= in_data;
        a_q <= ibuf[ia];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dense_lane #(
            .IN_COUNT (IN_COUNT),
            .DATA_SIZE(DATA_SIZE),
            .FRAC_BITS(FRAC_BITS),
            .RELU_EN  (RELU_EN)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (state == MAC && k == '0),
            .mac_en (state == MAC && k != '0),
            .bias_en(state == BIAS),
            .a      (a_q),
            .w      (weight_data[l*DATA_SIZE +: DATA_SIZE]),
            .b      (bias_data[l*DATA_SIZE +: DATA_SIZE]),
            .result (res[l])
        );
    end

endmodule

// File: tb/tb_dense_par.sv
// tb_dense_par: table-driven and scoreboard checks of dense_par in two configurations
module tb_dense_par;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel, start, in_valid, out_ready;
    logic [15:0] in_data;
    int          n_in, n_out;

    logic        a_ir, a_ov, a_ol, a_busy, b_ir, b_ov, b_ol, b_busy;
    logic [15:0] a_od, b_od;
    logic [6:0]  a_wa;
    logic [2:0]  a_ba;
    logic [1:0]  b_wa;
    logic [0:0]  b_ba;
    logic [31:0] a_wd, a_bd, b_wd, b_bd;

    logic        ir, ov, ol, busy_m;
    logic [15:0] od;
    assign ir     = sel ? b_ir : a_ir;
    assign ov     = sel ? b_ov : a_ov;
    assign ol     = sel ? b_ol : a_ol;
    assign od     = sel ? b_od : a_od;
    assign busy_m = sel ? b_busy : a_busy;

    dense_par #(.IN_COUNT(16), .OUT_COUNT(10), .DATA_SIZE(16), .FRAC_BITS(8), .LANES(2), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid & ~sel), .in_data(in_data),
        .in_ready(a_ir), .weight_adr(a_wa), .weight_data(a_wd), .bias_adr(a_ba), .bias_data(a_bd),
        .out_valid(a_ov), .out_data(a_od), .out_ready(out_ready & ~sel), .out_last(a_ol), .busy(a_busy));

    dense_par #(.IN_COUNT(4), .OUT_COUNT(2), .DATA_SIZE(16), .FRAC_BITS(8), .LANES(2), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid & sel), .in_data(in_data),
        .in_ready(b_ir), .weight_adr(b_wa), .weight_data(b_wd), .bias_adr(b_ba), .bias_data(b_bd),
        .out_valid(b_ov), .out_data(b_od), .out_ready(out_ready & sel), .out_last(b_ol), .busy(b_busy));

    logic [31:0] wrom [128];
    logic [31:0] brom [8];
    logic [15:0] ibuf [16];

    // synchronous ROM models, one read port per instance
    always_ff @(posedge clk) begin
        a_wd <= wrom[a_wa];
        a_bd <= brom[a_ba];
        b_wd <= wrom[7'(b_wa)];
        b_bd <= brom[3'(b_ba)];
    end

    typedef struct { logic [15:0] d; logic last; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0, npop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scoreboard: a word transfers at the next rising edge when valid and ready are both high here
    always @(negedge clk) begin
        if (!rst && ov && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", {16'h0, od}, 32'hFFFF_FFFF);
            else begin
                chk("out_data", {16'h0, od}, {16'h0, exp_q[0].d});
                chk("out_last", {31'h0, ol}, {31'h0, exp_q[0].last});
                void'(exp_q.pop_front());
            end
            npop++;
        end
    end

    task automatic use_dut(input bit s);
        sel   = s;
        n_in  = s ? 4 : 16;
        n_out = s ? 2 : 10;
    endtask

    task automatic fill(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < 16; i++) ibuf[i] = x;
        for (int r = 0; r < 128; r++) wrom[r] = {w, w};
        for (int r = 0; r < 8; r++) brom[r] = {b, b};
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) ibuf[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
        for (int r = 0; r < 128; r++) wrom[r] = {16'($urandom_range(0, 2047)) - 16'd1024, 16'($urandom_range(0, 2047)) - 16'd1024};
        for (int r = 0; r < 8; r++) brom[r] = {16'($urandom_range(0, 2047)) - 16'd1024, 16'($urandom_range(0, 2047)) - 16'd1024};
    endtask

    function automatic logic [15:0] model(input int o);
        longint s;
        int g, l;
        logic [31:0] row;
        g = o / 2;
        l = o % 2;
        s = 0;
        for (int i = 0; i < n_in; i++) begin
            row = wrom[g * n_in + i];
            s += longint'($signed(ibuf[i])) * longint'($signed(row[l*16 +: 16]));
        end
        row = brom[g];
        s += longint'($signed(row[l*16 +: 16])) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (!sel && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic push_const(input logic [15:0] e);
        for (int o = 0; o < n_out; o++) exp_q.push_back('{e, o == n_out - 1});
    endtask

    task automatic push_model();
        for (int o = 0; o < n_out; o++) exp_q.push_back('{model(o), o == n_out - 1});
    endtask

    task automatic run_frame(input int stall, input bit poke, input int abort_at);
        int idx, cyc, hold, wait_ab;
        bit xfer, seen;
        logic [15:0] held;
        idx = 0; hold = 0; wait_ab = 0; seen = 0; npop = 0; held = '0;
        start = 1; in_valid = 1; in_data = ibuf[0]; out_ready = (stall == 0);
        for (cyc = 1; cyc <= 4000; cyc++) begin
            xfer = in_valid && ir;
            @(posedge clk);
            #1;
            start = poke && ov;
            if (xfer) idx++;
            in_valid = poke || idx < n_in;
            if (idx < n_in) in_data = ibuf[idx];
            else in_data = 16'hDEAD;
            if (ov && !seen) begin
                seen = 1;
                chk("latency", cyc, 2 * n_in + 3);
            end
            if (stall > 0) begin
                if (out_ready) begin
                    out_ready = 0;
                    hold = 0;
                end else if (ov) begin
                    if (hold == 0) held = od;
                    else chk("stall_hold", {16'h0, od}, {16'h0, held});
                    hold++;
                    if (hold >= stall) out_ready = 1;
                end
            end
            if (abort_at > 0 && npop >= abort_at && busy_m && !ov) begin
                wait_ab++;
                if (wait_ab == 3) begin
                    rst = 1;
                    @(posedge clk);
                    #1;
                    rst = 0;
                    chk("abort_busy", {31'h0, busy_m}, 0);
                    chk("abort_valid", {31'h0, ov}, 0);
                    exp_q.delete();
                    break;
                end
            end
            if (seen && !busy_m && exp_q.size() == 0) break;
        end
        start = 0; in_valid = 0; out_ready = 0;
        chk("frame_queue_left", exp_q.size(), 0);
        chk("frame_end_busy", {31'h0, busy_m}, 0);
    endtask

    typedef struct { bit s; logic [15:0] x, w, b, e; } vec_t;
    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 16'h0100, 16'h0100, 16'h0000, 16'h0400};
        vt[1] = '{1'b0, 16'h7F00, 16'h7F00, 16'h0000, 16'h7FFF};
        vt[2] = '{1'b0, 16'h7F00, 16'h8100, 16'h0000, 16'h0000};
        vt[3] = '{1'b1, 16'h7F00, 16'h8100, 16'h0000, 16'h8000};
        vt[4] = '{1'b1, 16'h0060, 16'h0100, 16'hFE00, 16'hFF80};
        vt[5] = '{1'b0, 16'h0018, 16'h0100, 16'hFE00, 16'h0000};
        vt[6] = '{1'b1, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};
        vt[7] = '{1'b0, 16'h0200, 16'h0080, 16'h0100, 16'h1100};
        vt[8] = '{1'b1, 16'hFF00, 16'h0100, 16'h0300, 16'hFF00};
        use_dut(0);
        start = 0; in_valid = 0; in_data = '0; out_ready = 0; rst = 1;
        fill(16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_busy", {31'h0, a_busy}, 0);
        chk("rst_a_valid", {31'h0, a_ov}, 0);
        chk("rst_a_ready", {31'h0, a_ir}, 0);
        chk("rst_a_last", {31'h0, a_ol}, 0);
        chk("rst_a_data", {16'h0, a_od}, 0);
        chk("rst_a_wadr", {25'h0, a_wa}, 0);
        chk("rst_a_badr", {29'h0, a_ba}, 0);
        chk("rst_b_busy", {31'h0, b_busy}, 0);
        chk("rst_b_valid", {31'h0, b_ov}, 0);
        chk("rst_b_ready", {31'h0, b_ir}, 0);
        chk("rst_b_last", {31'h0, b_ol}, 0);
        chk("rst_b_data", {16'h0, b_od}, 0);
        chk("rst_b_wadr", {30'h0, b_wa}, 0);
        chk("rst_b_badr", {31'h0, b_ba}, 0);
        rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            use_dut(vt[i].s);
            fill(vt[i].x, vt[i].w, vt[i].b);
            push_const(vt[i].e);
            run_frame(0, 0, 0);
            repeat (2) @(posedge clk);
            #1;
        end
        use_dut(0);
        fill_rand();
        push_model();
        run_frame(5, 0, 0);
        fill_rand();
        push_model();
        run_frame(0, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("poke_no_restart", {31'h0, busy_m}, 0);
        fill_rand();
        push_model();
        run_frame(0, 0, 2);
        repeat (5) @(posedge clk);
        #1;
        chk("post_abort_valid", {31'h0, ov}, 0);
        chk("post_abort_busy", {31'h0, busy_m}, 0);
        fill(16'h0200, 16'h0080, 16'h0100);
        push_const(16'h1100);
        run_frame(0, 0, 0);
        use_dut(1);
        fill_rand();
        push_model();
        run_frame(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
